// File: rtl/mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mem_lsu_pkg
// Shared types and constants for the load/store unit of the 16-bit core.
//   - lsu_state_e : the unit's four-state transaction sequencer encoding
//   - DATA_W      : data-memory word width
//   - DEF_*       : default address / register-index widths and timeout limit
// Optional feature macro used elsewhere in this slice: LSU_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package mem_lsu_pkg;

  localparam int DATA_W          = 16;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_REG_W       = 3;
  localparam int DEF_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if
// Bundles the three handshakes around the load/store unit:
//   execute side : in_valid/in_ready, in_load, in_store, in_addr, in_wdata, in_rd
//   memory side  : mem_req, mem_we, mem_addr, mem_wdata, mem_gnt,
//                  mem_rvalid, mem_rdata
//   writeback    : wb_valid/wb_ready, wb_data, wb_rd
//   status       : busy, err
// Modports:
//   master : the load/store unit itself (drives memory requests, results)
//   slave  : the surroundings (execute stage, memory, writeback)
// ---------------------------------------------------------------------------
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W
);

  logic              in_valid;
  logic              in_ready;
  logic              in_load;
  logic              in_store;
  logic [DATA_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_W-1:0]  in_rd;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_rd;

  logic              busy;
  logic              err;

  modport master (
    input  in_valid, in_load, in_store, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_data, wb_rd,
    input  wb_ready,
    output busy, err
  );

  modport slave (
    output in_valid, in_load, in_store, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_data, wb_rd,
    output wb_ready,
    input  busy, err
  );

endinterface

// File: rtl/mem_lsu_watchdog.sv
// ---------------------------------------------------------------------------
// mem_lsu_watchdog
// Cycle counter that bounds how long the load/store unit may wait on memory.
// Only instantiated when LSU_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clear     : restart counting from zero (asserted on the edge entering
//               a waiting state)
//   count_en  : advance the count this cycle
//   expired   : high during the LIMIT-th cycle since the last clear
// ---------------------------------------------------------------------------
module mem_lsu_watchdog
  import mem_lsu_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  // Count saturates at LIMIT so a stalled enable can never wrap around
  // and fake a second expiry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (count_en && (count_q != CNT_W'(LIMIT))) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The first waiting cycle sees count 0, so LIMIT-1 marks the last one.
  assign expired = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
// Load/store initiator in front of the data-memory array. Takes one memory
// operation per handshake from execute, issues it on the memory port, waits
// for grant (and read data for loads) and hands load results to writeback.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_lsu_if.master (execute, memory and writeback handshakes,
//          plus busy / err status)
// Parameters: ADDR_W (memory word-address width), REG_W (register index
// width), TIMEOUT_CYC (watchdog limit, only with LSU_TIMEOUT_EN).
// Optional feature macro: LSU_TIMEOUT_EN -- abandons a request that sees no
// grant / read data within TIMEOUT_CYC cycles and pulses err.
// ---------------------------------------------------------------------------
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic       clk,
  input logic       rst,
  mem_lsu_if.master bus
);

  lsu_state_e        state_q;
  lsu_state_e        state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_W-1:0]  rd_q;
  logic              store_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              timeout_hit;
  logic              err_q;

  // Only the low ADDR_W address bits reach the memory array.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.in_addr[DATA_W-1:ADDR_W];

  // An operation with neither kind bit set is consumed and dropped.
  assign accept = (state_q == IDLE) && bus.in_valid && (bus.in_load || bus.in_store);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Grant / read data take priority over a timeout
  // landing in the same cycle; rvalid is only looked at in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_gnt)      state_d = store_q ? IDLE : WAIT;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT: begin
        if (bus.mem_rvalid)   state_d = RESP;
        else if (timeout_hit) state_d = IDLE;
      end
      RESP: begin
        if (bus.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so nothing on the memory or
  // execute side depends combinationally on any input.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.mem_req   = (state_q == REQ);
    bus.mem_we    = (state_q == REQ) && store_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.wb_valid  = (state_q == RESP);
    bus.wb_data   = rdata_q;
    bus.wb_rd     = rd_q;
    bus.busy      = (state_q != IDLE);
    bus.err       = err_q;
  end

  // Request latch and load-data capture. A simultaneous load+store is
  // treated as a load, so the write flag needs load low.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      store_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.in_addr[ADDR_W-1:0];
        wdata_q <= bus.in_wdata;
        rd_q    <= bus.in_rd;
        store_q <= bus.in_store && !bus.in_load;
      end
      if ((state_q == WAIT) && bus.mem_rvalid) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic wd_clear;
  logic wd_count_en;
  logic wd_expired;

  // Restart the watchdog on every entry into a waiting state (including
  // the REQ -> WAIT hand-over) and let it run while waiting.
  assign wd_clear    = (state_d != state_q) && ((state_d == REQ) || (state_d == WAIT));
  assign wd_count_en = (state_q == REQ) || (state_q == WAIT);
  assign timeout_hit = wd_expired;

  mem_lsu_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  // err is a single-cycle pulse following the abandoning edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wd_expired &&
               (((state_q == REQ)  && !bus.mem_gnt) ||
                ((state_q == WAIT) && !bus.mem_rvalid));
    end
  end
`else
  // Without the watchdog the unit waits on memory indefinitely.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign timeout_hit    = 1'b0;
  assign err_q          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu
// Self-checking bench for mem_lsu: a table of directed operations, a few
// hand-written multi-cycle sequences, and randomized operations checked
// against a word-array model of data memory.
// ---------------------------------------------------------------------------
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int AW = 8;
  localparam int RW = 3;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(AW), .REG_W(RW)) bus ();

  mem_lsu #(
    .ADDR_W      (AW),
    .REG_W       (RW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_load;
    bit          is_store;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  rd;
    int          gnt_delay;
    int          rv_delay;
    int          wb_delay;
    bit          early_rvalid;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  // mem_arr is the responder's storage; golden is the expected memory
  // contents derived purely from the issued operations.
  logic [15:0] mem_arr [256];
  logic [15:0] golden  [256];

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One whole operation: issue, memory response, writeback handshake.
  task automatic apply_stimulus(input vec_t v);
    logic [15:0] rsp;
    bit          exp_mem;
    bit          exp_we;
    rsp     = 16'h0;
    exp_mem = v.is_load || v.is_store;
    exp_we  = v.is_store && !v.is_load;

    check_output("start_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_load  = v.is_load;
    bus.in_store = v.is_store;
    bus.in_addr  = v.addr;
    bus.in_wdata = v.wdata;
    bus.in_rd    = v.rd;
    tick();
    bus.in_valid = 1'b0;
    bus.in_load  = 1'b0;
    bus.in_store = 1'b0;
    bus.in_addr  = 16'hxxxx;
    bus.in_wdata = 16'hxxxx;

    if (!exp_mem) begin
      check_output("drop_mem_req", bus.mem_req, 0);
      check_output("drop_in_ready", bus.in_ready, 1);
      check_output("drop_busy", bus.busy, 0);
      return;
    end

    for (int i = 0; i <= v.gnt_delay; i++) begin
      check_output("req_mem_req", bus.mem_req, 1);
      check_output("req_mem_we", bus.mem_we, exp_we);
      check_output("req_mem_addr", bus.mem_addr, v.exp_addr);
      if (exp_we) check_output("req_mem_wdata", bus.mem_wdata, v.wdata);
      check_output("req_in_ready", bus.in_ready, 0);
      if (i == v.gnt_delay) begin
        bus.mem_gnt = 1'b1;
        if (v.early_rvalid) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 16'hDEAD;
        end
        rsp = mem_arr[bus.mem_addr];
        if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
      end
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check_output("post_gnt_mem_req", bus.mem_req, 0);

    if (exp_we) begin
      check_output("store_in_ready", bus.in_ready, 1);
      check_output("store_wb_valid", bus.wb_valid, 0);
      check_output("store_busy", bus.busy, 0);
      return;
    end

    for (int i = 0; i < v.rv_delay; i++) begin
      check_output("wait_wb_valid", bus.wb_valid, 0);
      check_output("wait_busy", bus.busy, 1);
      bus.mem_rdata = 16'($urandom);
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rsp;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;

    for (int i = 0; i <= v.wb_delay; i++) begin
      check_output("resp_wb_valid", bus.wb_valid, 1);
      check_output("resp_wb_data", bus.wb_data, v.exp_data);
      check_output("resp_wb_rd", bus.wb_rd, v.rd);
      check_output("resp_in_ready", bus.in_ready, 0);
      if (i == v.wb_delay) bus.wb_ready = 1'b1;
      tick();
    end
    bus.wb_ready = 1'b0;
    check_output("done_wb_valid", bus.wb_valid, 0);
    check_output("done_in_ready", bus.in_ready, 1);
    check_output("done_err", bus.err, 0);
  endtask

  // Expected-memory bookkeeping for a completed operation.
  task automatic model_commit(input vec_t v);
    if (v.is_store && !v.is_load) golden[v.addr[7:0]] = v.wdata;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    vec_t v;
    int   n;

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'h0;
      golden[i]  = 16'h0;
    end

    // ld st addr wdata rd gnt rv wb early exp_addr exp_data
    vecs[0] = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 3'd0, 0, 0, 0, 1'b0, 8'h12, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 3'd3, 2, 0, 0, 1'b0, 8'h12, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 3'd5, 0, 1, 5, 1'b1, 8'h12, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'hFF34, 16'h1234, 3'd0, 1, 0, 0, 1'b0, 8'h34, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'hFF34, 16'hAAAA, 3'd6, 0, 0, 0, 1'b0, 8'h34, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'hFF34, 16'h0000, 3'd7, 0, 0, 0, 1'b0, 8'h34, 16'h1234};
    vecs[6] = '{1'b1, 1'b1, 16'h0012, 16'h5555, 3'd1, 1, 0, 0, 1'b0, 8'h12, 16'hBEEF};
    vecs[7] = '{1'b1, 1'b0, 16'h0034, 16'h0000, 3'd2, 3, 2, 1, 1'b0, 8'h34, 16'h1234};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_load    = 1'b0;
    bus.in_store   = 1'b0;
    bus.in_addr    = 16'h0;
    bus.in_wdata   = 16'h0;
    bus.in_rd      = 3'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0;
    bus.wb_ready   = 1'b0;
    tick();
    tick();
    check_output("rst_mem_req", bus.mem_req, 0);
    check_output("rst_mem_we", bus.mem_we, 0);
    check_output("rst_mem_addr", bus.mem_addr, 0);
    check_output("rst_mem_wdata", bus.mem_wdata, 0);
    check_output("rst_wb_valid", bus.wb_valid, 0);
    check_output("rst_wb_data", bus.wb_data, 0);
    check_output("rst_wb_rd", bus.wb_rd, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_err", bus.err, 0);
    rst = 1'b0;
    tick();
    check_output("rst_in_ready", bus.in_ready, 1);

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      model_commit(vecs[i]);
    end

    $display("[TB] reset while waiting for read data");
    bus.in_valid = 1'b1;
    bus.in_load  = 1'b1;
    bus.in_addr  = 16'h0012;
    bus.in_rd    = 3'd4;
    tick();
    bus.in_valid = 1'b0;
    bus.in_load  = 1'b0;
    bus.mem_gnt  = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check_output("wait_busy_pre_rst", bus.busy, 1);
    check_output("wait_mem_req_pre_rst", bus.mem_req, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort_mem_req", bus.mem_req, 0);
    check_output("abort_wb_valid", bus.wb_valid, 0);
    check_output("abort_in_ready", bus.in_ready, 1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hCAFE;
    tick();
    bus.mem_rvalid = 1'b0;
    check_output("late_rvalid_wb_valid", bus.wb_valid, 0);
    check_output("late_rvalid_busy", bus.busy, 0);
    tick();
    check_output("late_rvalid_wb_valid2", bus.wb_valid, 0);

`ifdef LSU_TIMEOUT_EN
    $display("[TB] grant never arrives");
    bus.in_valid = 1'b1;
    bus.in_store = 1'b1;
    bus.in_addr  = 16'h0040;
    bus.in_wdata = 16'h7777;
    tick();
    bus.in_valid = 1'b0;
    bus.in_store = 1'b0;
    n = 0;
    while (bus.mem_req && n < 40) begin
      check_output("to_err_low", bus.err, 0);
      n++;
      tick();
    end
    check_output("to_req_cycles", n, TO);
    check_output("to_err_pulse", bus.err, 1);
    check_output("to_in_ready", bus.in_ready, 1);
    tick();
    check_output("to_err_clear", bus.err, 0);
    check_output("to_wb_valid", bus.wb_valid, 0);
`endif

    $display("[TB] randomized operations");
    for (int k = 0; k < 60; k++) begin
      int r;
      r              = int'($urandom_range(0, 9));
      v.is_load      = (r >= 5);
      v.is_store     = (r >= 1 && r <= 4) || (r == 9);
      v.addr         = 16'($urandom) & 16'hFF07;
      v.wdata        = 16'($urandom);
      v.rd           = 3'($urandom);
      v.gnt_delay    = int'($urandom_range(0, 3));
      v.rv_delay     = int'($urandom_range(0, 3));
      v.wb_delay     = int'($urandom_range(0, 3));
      v.early_rvalid = 1'($urandom);
      v.exp_addr     = v.addr[7:0];
      v.exp_data     = golden[v.addr[7:0]];
      apply_stimulus(v);
      model_commit(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator for the 16-bit processor's data memory. It accepts one memory operation per handshake from the execute stage, drives the request side of the data-memory port, waits for the grant and any read data, and hands load results to writeback. It is the requester that sits in front of the data-memory array and is the only master on that port.

## Interface
- ADDR_W, 8, word-address width into data memory (256 words)
- REG_W, 3, destination register index width
- TIMEOUT_CYC, 15, watchdog limit in cycles; used only with LSU_TIMEOUT_EN
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  unit can accept; high only in IDLE
- in_load / in_store  in  1 / 1  operation kind; both high is treated as load
- in_addr  in  16  word address; bits above ADDR_W ignored
- in_wdata  in  16  store data
- in_rd  in  REG_W  load destination register
- mem_req  out  1  request valid to data memory
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  16  write data
- mem_gnt  in  1  memory accepts the current request
- mem_rvalid / mem_rdata  in  1 / 16  read data return, at least one cycle after grant
- wb_valid / wb_ready  out / in  1 / 1  load-result handshake to writeback
- wb_data / wb_rd  out  16 / REG_W  load data and destination register
- busy  out  1  state != IDLE
- err  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid: if load or store, latch addr/wdata/rd/kind, go REQ; if neither, drop silently, stay IDLE.
- REQ: mem_req=1, mem_we=latched store, mem_addr/mem_wdata from latch, held stable until mem_gnt. On gnt: store -> IDLE; load -> WAIT.
- WAIT: mem_req=0. On mem_rvalid: capture mem_rdata into wb_data, go RESP.
- RESP: wb_valid=1, wb_data/wb_rd held stable until wb_ready; then -> IDLE.
- mem_rvalid outside WAIT is ignored (includes rvalid arriving in the same cycle as gnt).
- Reset outputs: state IDLE, in_ready=1 the first cycle after rst drops, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0, busy=0, err=0.
- Reset mid-operation abandons the transaction: mem_req and wb_valid low the cycle after rst sampled; a late rvalid is ignored.

## Timing
- Accept at edge N -> mem_req high in cycle N+1 (registered outputs, no combinational path in->mem).
- Store: gnt sampled at edge M -> in_ready high in cycle M+1. Minimum store throughput: one per 2 cycles.
- Load: rvalid sampled at edge K -> wb_valid high in cycle K+1; wb_ready sampled at edge R -> in_ready high in cycle R+1. Minimum load occupancy: 4 cycles with 1-cycle memory.
- in_ready never depends combinationally on wb_ready or mem_gnt.

## Configuration
- LSU_TIMEOUT_EN defined: counter clears on entering REQ or WAIT, increments each cycle in those states; when it reaches TIMEOUT_CYC without gnt (REQ) or rvalid (WAIT), drop mem_req, pulse err for one cycle, return to IDLE, no writeback.
- Undefined: unit waits indefinitely; err tied 0; TIMEOUT_CYC unused.

## Structure
- lsu_pkg: state enum (IDLE, REQ, WAIT, RESP), DATA_W=16 constant, default ADDR_W/REG_W values.
- One sub-module, lsu_watchdog (load/clear/expire counter), instantiated only under LSU_TIMEOUT_EN.

## Test plan
- Store addr 16'h0012, data 16'hBEEF, gnt same cycle as req -> one cycle mem_req=1, mem_we=1, mem_addr=8'h12, mem_wdata=16'hBEEF; in_ready back next cycle; no wb_valid.
- Load addr 16'h0012, rd=3, gnt after 2 cycles, rvalid 1 cycle later with 16'hBEEF -> mem_addr stable throughout REQ, wb_valid with wb_data=16'hBEEF, wb_rd=3.
- Load with wb_ready low 5 cycles -> wb_valid/wb_data held 5+ cycles, in_ready low until accepted.
- in_addr 16'hFF34 -> mem_addr=8'h34; in_valid with neither load nor store -> no mem_req, in_ready stays 1.
- rst asserted in WAIT, then rvalid arrives -> no wb_valid, mem_req=0, in_ready=1 after reset.
- LSU_TIMEOUT_EN, gnt never asserted -> mem_req drops after 15 cycles, err high exactly one cycle, in_ready=1 next cycle.
